tse_descriptor_dispatch: RTL and testbench
==========================================

Name: tse_descriptor_dispatch

Overview:
Upstream neighbour of the per-port network output process. Buffers forwarding descriptors (tsntag, pkt_type, bufid, outport bitmap) coming from the network input lookup, then replicates each one onto the network-side descriptor interface of output port 0 and/or port 1, holding each request until that port acks. Announces the multicast reference count of each bufid to the buffer manager, and frees bufids whose bitmap is empty.

Parameters:
FIFO_DEPTH, 4, descriptor FIFO entries; power of two, 2..16.
FIFO_AW, 2, log2(FIFO_DEPTH); pointer width. The occupancy counter is FIFO_AW+1 bits.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
iv_tsntag  in  48  descriptor TSN tag
iv_pkt_type  in  3  packet type
iv_bufid  in  9  packet buffer id
iv_outport  in  2  outport bitmap; bit0 = port0, bit1 = port1
i_descriptor_wr  in  1  descriptor write strobe, one cycle per descriptor
o_fifo_full  out  1  FIFO holds FIFO_DEPTH entries
ov_tsntag_p0 / ov_tsntag_p1  out  48  per-port tag
ov_pkt_type_p0 / ov_pkt_type_p1  out  3  per-port type
ov_bufid_p0 / ov_bufid_p1  out  9  per-port bufid
o_descriptor_wr_p0 / o_descriptor_wr_p1  out  1  per-port request, level until acked
i_descriptor_ack_p0 / i_descriptor_ack_p1  in  1  per-port ack, one-cycle pulse
ov_refcnt_bufid  out  9  bufid being announced
ov_refcnt  out  2  number of ports that will read the bufid (1 or 2)
o_refcnt_wr  out  1  reference-count write pulse
ov_free_bufid  out  9  bufid to release
o_free_bufid_wr  out  1  release pulse

Behaviour:
- Reset: all outputs 0; FIFO empty; pointers and counter 0; FSM in IDLE. An asserted i_rst mid-transfer drops every queued and in-flight descriptor immediately.
- Push:
  - On i_descriptor_wr with count < FIFO_DEPTH, the descriptor is written at wptr; wptr wraps modulo FIFO_DEPTH.
  - Writes while full are discarded and have no other effect.
  - o_fifo_full is registered and equals (count == FIFO_DEPTH).
  - A push and a pop in the same cycle leave count unchanged and are legal while full.
- FSM: IDLE, ISSUE, WAIT_ACK.
  - IDLE, FIFO not empty, head outport == 0: pulse o_free_bufid_wr for one cycle with the head bufid, pop, stay in IDLE.
  - IDLE, FIFO not empty, head outport != 0: latch the head into the working register, pop, go to ISSUE. In the same cycle pulse o_refcnt_wr with ov_refcnt = popcount(outport).
  - ISSUE: assert o_descriptor_wr_pN and drive fields for each port whose bitmap bit is set. Clear ack_seen[1:0]. Go to WAIT_ACK.
  - WAIT_ACK: on i_descriptor_ack_pN, set ack_seen[N] and deassert o_descriptor_wr_pN on the next edge. When every targeted port has acked (acks may arrive in the same or different cycles), go to IDLE.
  - Acks on untargeted ports, and acks received in IDLE, are ignored.
- Fields on a port stay stable while its wr is high. Both ports are issued in the same cycle for multicast.
- Latency: a push into an empty FIFO at cycle T gives o_refcnt_wr at T+1 and o_descriptor_wr_pN at T+2. Best-case throughput is one descriptor per 3 cycles (IDLE, ISSUE, WAIT_ACK with ack in its first cycle).
- Only one descriptor is in flight; the next head waits in the FIFO.

Optional Feature:
DISPATCH_STATS_EN
- Defined:
  - Adds ov_dispatch_cnt_p0, ov_dispatch_cnt_p1, ov_drop_cnt (32 bits each, outputs).
  - The p0/p1 counters increment once per ack received on that port. ov_drop_cnt increments once per discarded write-when-full and once per zero-bitmap free.
  - All counters wrap at 2^32, reset to 0, and are held at 0 during i_rst.
- Undefined: these ports and registers do not exist; the rest of the block is unchanged.

Test Plan:
- Unicast: push {bufid=9'h005, outport=2'b01} at T; ack_p0 at T+4 -> o_refcnt_wr at T+1 with ov_refcnt=1; o_descriptor_wr_p0 high T+2..T+4 with ov_bufid_p0=5; low at T+5; p1 stays idle.
- Multicast with skewed acks: outport=2'b11, bufid=9'h1A0; ack_p1 in the first WAIT_ACK cycle, ack_p0 three cycles later -> ov_refcnt=2; wr_p1 drops after 1 cycle, wr_p0 after 4; the next descriptor is not issued until both acks are seen.
- Zero bitmap: push bufid=9'h033 with outport=0 -> one-cycle o_free_bufid_wr with ov_free_bufid=33; no o_refcnt_wr and no per-port wr.
- Full FIFO: hold acks low, push 6 descriptors (bufids 1..6) -> the first is popped into WAIT_ACK, 2..5 fill the FIFO, o_fifo_full=1, 6 is discarded. Release acks -> exactly bufids 1..5 are issued, in order.
- Simultaneous push/pop while full, plus pointer wrap: push during the pop cycle -> count stays FIFO_DEPTH; after 3*FIFO_DEPTH descriptors, ordering and data are intact.
- Async reset mid-WAIT_ACK: assert i_rst between clock edges -> o_descriptor_wr_p0/p1 drop immediately; after release the FIFO is empty and the FSM is in IDLE. With DISPATCH_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/tse_descriptor_dispatch.sv
// ----------------------------------------------------------------------------
// tse_descriptor_dispatch
//
// Purpose:
//   Buffers forwarding descriptors from the network input lookup in a small
//   FIFO and replicates each one onto the per-port descriptor interfaces of
//   output port 0 and/or port 1, holding each request until that port acks.
//   Announces the multicast reference count of every forwarded bufid to the
//   buffer manager and releases bufids whose outport bitmap is empty.
//   Only one descriptor is in flight at a time; later heads wait in the FIFO.
//
// Parameters:
//   FIFO_DEPTH  descriptor FIFO entries (power of two, 2..16)
//   FIFO_AW     log2(FIFO_DEPTH); the occupancy counter is FIFO_AW+1 bits
//
// Optional feature macro: DISPATCH_STATS_EN
//   Defined   : adds ov_dispatch_cnt_p0/_p1 and ov_drop_cnt (32-bit wrapping
//               counters, cleared by i_rst).
//   Undefined : those ports and registers do not exist.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   iv_tsntag/pkt_type/bufid/outport, i_descriptor_wr
//                                 input descriptor and its one-cycle strobe
//   o_fifo_full                   registered, FIFO holds FIFO_DEPTH entries
//   ov_*_p0/_p1, o_descriptor_wr_p0/_p1, i_descriptor_ack_p0/_p1
//                                 per-port descriptor request and ack
//   ov_refcnt_bufid, ov_refcnt, o_refcnt_wr
//                                 reference-count announcement pulse
//   ov_free_bufid, o_free_bufid_wr
//                                 release pulse for zero-bitmap descriptors
//   ov_fsm_state                  current dispatch FSM state (debug)
//
// Per-port handshake: o_descriptor_wr_pN is a level request; the fields on
// that port are valid and stable for as long as it is high. The port answers
// with a one-cycle i_descriptor_ack_pN pulse during WAIT_ACK and the request
// drops on the following edge. Acks on untargeted ports or outside WAIT_ACK
// are ignored.
// ----------------------------------------------------------------------------
module tse_descriptor_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] iv_tsntag,
    input  logic [2:0]  iv_pkt_type,
    input  logic [8:0]  iv_bufid,
    input  logic [1:0]  iv_outport,
    input  logic        i_descriptor_wr,
    output logic        o_fifo_full,
    output logic [47:0] ov_tsntag_p0,
    output logic [2:0]  ov_pkt_type_p0,
    output logic [8:0]  ov_bufid_p0,
    output logic        o_descriptor_wr_p0,
    input  logic        i_descriptor_ack_p0,
    output logic [47:0] ov_tsntag_p1,
    output logic [2:0]  ov_pkt_type_p1,
    output logic [8:0]  ov_bufid_p1,
    output logic        o_descriptor_wr_p1,
    input  logic        i_descriptor_ack_p1,
    output logic [8:0]  ov_refcnt_bufid,
    output logic [1:0]  ov_refcnt,
    output logic        o_refcnt_wr,
    output logic [8:0]  ov_free_bufid,
    output logic        o_free_bufid_wr,
`ifdef DISPATCH_STATS_EN
    output logic [31:0] ov_dispatch_cnt_p0,
    output logic [31:0] ov_dispatch_cnt_p1,
    output logic [31:0] ov_drop_cnt,
`endif
    output logic [1:0]  ov_fsm_state
);

    typedef struct packed {
        logic [47:0] tag;
        logic [2:0]  ptype;
        logic [8:0]  bufid;
        logic [1:0]  outport;
    } desc_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    desc_t              mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q;
    logic               empty;
    logic               push_ok;
    logic               pop;
    desc_t              head;

    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    // A write while full is only taken when the FSM pops in the same cycle,
    // which keeps the occupancy at FIFO_DEPTH.
    assign push_ok = i_descriptor_wr && (!full_q || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is data only; validity is tracked by the pointers and counter.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= {iv_tsntag, iv_pkt_type, iv_bufid, iv_outport};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    desc_t      work_q;
    logic       load;
    logic [1:0] wr_q, wr_d;
    logic [1:0] ack_seen_q, ack_seen_d;
    logic [1:0] acked;
    logic       refcnt_wr;
    logic       free_wr;

    // Acks that count: only in WAIT_ACK, only on targeted ports, only once.
    assign acked = (state_q == S_WAIT_ACK)
                 ? ({i_descriptor_ack_p1, i_descriptor_ack_p0} & work_q.outport & ~ack_seen_q)
                 : 2'b00;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        ack_seen_d = ack_seen_q;
        pop        = 1'b0;
        load       = 1'b0;
        refcnt_wr  = 1'b0;
        free_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.outport == 2'b00) begin
                        free_wr = 1'b1;
                    end else begin
                        load      = 1'b1;
                        refcnt_wr = 1'b1;
                        // Request registers rise on this edge so they are
                        // already high during ISSUE.
                        wr_d      = head.outport;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                ack_seen_d = 2'b00;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                ack_seen_d = ack_seen_q | acked;
                wr_d       = wr_q & ~acked;
                if ((ack_seen_d & work_q.outport) == work_q.outport) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            wr_q       <= 2'b00;
            ack_seen_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            ack_seen_q <= ack_seen_d;
            if (load) begin
                work_q <= head;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_fifo_full        = full_q;
    assign ov_fsm_state       = state_q;

    assign o_descriptor_wr_p0 = wr_q[0];
    assign ov_tsntag_p0       = wr_q[0] ? work_q.tag   : '0;
    assign ov_pkt_type_p0     = wr_q[0] ? work_q.ptype : '0;
    assign ov_bufid_p0        = wr_q[0] ? work_q.bufid : '0;

    assign o_descriptor_wr_p1 = wr_q[1];
    assign ov_tsntag_p1       = wr_q[1] ? work_q.tag   : '0;
    assign ov_pkt_type_p1     = wr_q[1] ? work_q.ptype : '0;
    assign ov_bufid_p1        = wr_q[1] ? work_q.bufid : '0;

    // Reference count is the popcount of the (non-zero) head bitmap.
    assign o_refcnt_wr        = refcnt_wr;
    assign ov_refcnt_bufid    = refcnt_wr ? head.bufid : '0;
    assign ov_refcnt          = refcnt_wr
                              ? {head.outport[1] & head.outport[0], head.outport[1] ^ head.outport[0]}
                              : 2'b00;

    assign o_free_bufid_wr    = free_wr;
    assign ov_free_bufid      = free_wr ? head.bufid : '0;

`ifdef DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] disp_p0_q;
    logic [31:0] disp_p1_q;
    logic [31:0] drop_cnt_q;
    logic        drop_full;

    assign drop_full = i_descriptor_wr && !push_ok;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            disp_p0_q  <= '0;
            disp_p1_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            disp_p0_q  <= disp_p0_q + 32'(acked[0]);
            disp_p1_q  <= disp_p1_q + 32'(acked[1]);
            // A full-drop and a zero-bitmap free can coincide in one cycle.
            drop_cnt_q <= drop_cnt_q + 32'(drop_full) + 32'(free_wr);
        end
    end

    assign ov_dispatch_cnt_p0 = disp_p0_q;
    assign ov_dispatch_cnt_p1 = disp_p1_q;
    assign ov_drop_cnt        = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tse_descriptor_dispatch.sv
module tb_tse_descriptor_dispatch;

  localparam int D  = 4;
  localparam int AW = 2;
  localparam int DW = 62;

  typedef struct packed {
    logic [47:0] tag;
    logic [2:0]  ptype;
    logic [8:0]  bufid;
    logic [1:0]  outport;
  } desc_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [47:0] iv_tsntag;
  logic [2:0]  iv_pkt_type;
  logic [8:0]  iv_bufid;
  logic [1:0]  iv_outport;
  logic        i_descriptor_wr;
  logic        o_fifo_full;
  logic [47:0] ov_tsntag_p0, ov_tsntag_p1;
  logic [2:0]  ov_pkt_type_p0, ov_pkt_type_p1;
  logic [8:0]  ov_bufid_p0, ov_bufid_p1;
  logic        o_descriptor_wr_p0, o_descriptor_wr_p1;
  logic        i_descriptor_ack_p0, i_descriptor_ack_p1;
  logic [8:0]  ov_refcnt_bufid;
  logic [1:0]  ov_refcnt;
  logic        o_refcnt_wr;
  logic [8:0]  ov_free_bufid;
  logic        o_free_bufid_wr;
  logic [1:0]  ov_fsm_state;
`ifdef DISPATCH_STATS_EN
  logic [31:0] ov_dispatch_cnt_p0, ov_dispatch_cnt_p1, ov_drop_cnt;
`endif

  logic man_ack0, man_ack1, a_ack0, a_ack1, auto_ack;
  assign i_descriptor_ack_p0 = man_ack0 | a_ack0;
  assign i_descriptor_ack_p1 = man_ack1 | a_ack1;

  tse_descriptor_dispatch #(.FIFO_DEPTH(D), .FIFO_AW(AW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .iv_tsntag(iv_tsntag),
    .iv_pkt_type(iv_pkt_type),
    .iv_bufid(iv_bufid),
    .iv_outport(iv_outport),
    .i_descriptor_wr(i_descriptor_wr),
    .o_fifo_full(o_fifo_full),
    .ov_tsntag_p0(ov_tsntag_p0),
    .ov_pkt_type_p0(ov_pkt_type_p0),
    .ov_bufid_p0(ov_bufid_p0),
    .o_descriptor_wr_p0(o_descriptor_wr_p0),
    .i_descriptor_ack_p0(i_descriptor_ack_p0),
    .ov_tsntag_p1(ov_tsntag_p1),
    .ov_pkt_type_p1(ov_pkt_type_p1),
    .ov_bufid_p1(ov_bufid_p1),
    .o_descriptor_wr_p1(o_descriptor_wr_p1),
    .i_descriptor_ack_p1(i_descriptor_ack_p1),
    .ov_refcnt_bufid(ov_refcnt_bufid),
    .ov_refcnt(ov_refcnt),
    .o_refcnt_wr(o_refcnt_wr),
    .ov_free_bufid(ov_free_bufid),
    .o_free_bufid_wr(o_free_bufid_wr),
`ifdef DISPATCH_STATS_EN
    .ov_dispatch_cnt_p0(ov_dispatch_cnt_p0),
    .ov_dispatch_cnt_p1(ov_dispatch_cnt_p1),
    .ov_drop_cnt(ov_drop_cnt),
`endif
    .ov_fsm_state(ov_fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [8:0]    issued_q[$];
  desc_t         cur;
  int            m_cnt, m_drop, m_free, m_ack0, m_ack1, m_acc, m_pops;
  logic [1:0]    m_wr;
  logic          is_issue;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model + scoreboard, sampled on the falling edge.
  task automatic monitor();
    desc_t      h;
    logic       exp_pop, exp_ref, acc;
    logic [1:0] ack, nxt, pc;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_cnt = 0; m_wr = 2'b00; is_issue = 1'b0;
        m_drop = 0; m_free = 0; m_ack0 = 0; m_ack1 = 0; m_acc = 0; m_pops = 0;
      end else begin
        exp_ref = 1'b0;
        h = '0;
        n_checks++;
        if (o_fifo_full !== (m_cnt == D))
          $display("FAIL sb_full: o_fifo_full=%b required %b (count %0d)", o_fifo_full, (m_cnt == D), m_cnt);
        else n_pass++;

        exp_pop = (m_cnt > 0) && (m_wr == 2'b00);
        n_checks++;
        if (!exp_pop) begin
          if ({o_refcnt_wr, o_free_bufid_wr} !== 2'b00)
            $display("FAIL sb_pulse: refcnt_wr=%b free_wr=%b required 0 0", o_refcnt_wr, o_free_bufid_wr);
          else n_pass++;
        end else begin
          h = desc_t'(exp_q.pop_front());
          m_pops++;
          exp_ref = (h.outport != 2'b00);
          pc = {1'b0, h.outport[0]} + {1'b0, h.outport[1]};
          if (exp_ref) begin
            if (o_refcnt_wr !== 1'b1 || o_free_bufid_wr !== 1'b0 || ov_refcnt_bufid !== h.bufid || ov_refcnt !== pc)
              $display("FAIL sb_refcnt: wr=%b free=%b bufid=%h cnt=%0d required wr=1 free=0 bufid=%h cnt=%0d",
                       o_refcnt_wr, o_free_bufid_wr, ov_refcnt_bufid, ov_refcnt, h.bufid, pc);
            else n_pass++;
            cur = h;
            issued_q.push_back(h.bufid);
          end else begin
            if (o_free_bufid_wr !== 1'b1 || o_refcnt_wr !== 1'b0 || ov_free_bufid !== h.bufid)
              $display("FAIL sb_free: free=%b refcnt_wr=%b bufid=%h required free=1 refcnt_wr=0 bufid=%h",
                       o_free_bufid_wr, o_refcnt_wr, ov_free_bufid, h.bufid);
            else n_pass++;
            m_free++;
          end
        end

        n_checks++;
        if ({o_descriptor_wr_p1, o_descriptor_wr_p0} !== m_wr ||
            (m_wr[0] && {ov_tsntag_p0, ov_pkt_type_p0, ov_bufid_p0} !== {cur.tag, cur.ptype, cur.bufid}) ||
            (m_wr[1] && {ov_tsntag_p1, ov_pkt_type_p1, ov_bufid_p1} !== {cur.tag, cur.ptype, cur.bufid}))
          $display("FAIL sb_port: wr=%b%b bufid_p0=%h bufid_p1=%h required wr=%b bufid=%h",
                   o_descriptor_wr_p1, o_descriptor_wr_p0, ov_bufid_p0, ov_bufid_p1, m_wr, cur.bufid);
        else n_pass++;

        ack = {i_descriptor_ack_p1, i_descriptor_ack_p0};
        if (!is_issue) begin
          if (m_wr[0] && ack[0]) m_ack0++;
          if (m_wr[1] && ack[1]) m_ack1++;
        end
        nxt = is_issue ? m_wr : (m_wr & ~ack);
        is_issue = exp_pop && exp_ref;
        if (exp_pop && exp_ref) nxt = h.outport;
        m_wr = nxt;

        acc = i_descriptor_wr && ((m_cnt < D) || exp_pop);
        if (acc) begin
          exp_q.push_back({iv_tsntag, iv_pkt_type, iv_bufid, iv_outport});
          m_acc++;
        end else if (i_descriptor_wr) begin
          m_drop++;
        end
        m_cnt = m_cnt + int'(acc) - int'(exp_pop);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Auto-ack responder: acks a request 2..4 cycles after it rises.
  task automatic ack_driver();
    int hi0 = 0, hi1 = 0, d0 = 2, d1 = 2;
    forever begin
      tick();
      if (o_descriptor_wr_p0) hi0++; else hi0 = 0;
      if (o_descriptor_wr_p1) hi1++; else hi1 = 0;
      if (hi0 == 1) d0 = $urandom_range(2, 4);
      if (hi1 == 1) d1 = $urandom_range(2, 4);
      a_ack0 = auto_ack && o_descriptor_wr_p0 && (hi0 >= d0) && !a_ack0;
      a_ack1 = auto_ack && o_descriptor_wr_p1 && (hi1 >= d1) && !a_ack1;
    end
  endtask

  task automatic drive(input logic wr, input logic [8:0] bufid, input logic [1:0] port);
    i_descriptor_wr = wr;
    iv_bufid        = bufid;
    iv_outport      = port;
    iv_tsntag       = {39'h12_3456_789A, bufid};
    iv_pkt_type     = bufid[2:0];
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(m_cnt == 0 && m_wr == 2'b00) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= budget) $display("FAIL %s_drain: busy after %0d cycles, queued=%0d, required idle", name, budget, m_cnt);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({o_fifo_full, o_descriptor_wr_p0, o_descriptor_wr_p1, ov_tsntag_p0, ov_tsntag_p1, ov_bufid_p0, ov_bufid_p1,
         ov_pkt_type_p0, ov_pkt_type_p1, o_refcnt_wr, ov_refcnt, ov_refcnt_bufid, o_free_bufid_wr, ov_free_bufid,
         ov_fsm_state} !== '0)
      $display("FAIL reset_outputs: some output nonzero (full=%b wr=%b%b state=%0d) required all 0",
               o_fifo_full, o_descriptor_wr_p1, o_descriptor_wr_p0, ov_fsm_state);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unicast();
    logic er, ew;
    for (int c = 0; c <= 6; c++) begin
      drive(c == 0, 9'h005, 2'b01);
      man_ack0 = (c == 4);
      @(negedge clk);
      er = (c == 1);
      ew = (c >= 2 && c <= 4);
      n_checks++;
      if (o_refcnt_wr !== er || (er && ov_refcnt !== 2'd1) || o_descriptor_wr_p0 !== ew ||
          (ew && ov_bufid_p0 !== 9'h005) || o_descriptor_wr_p1 !== 1'b0)
        $display("FAIL unicast c=%0d: refcnt_wr=%b cnt=%0d wr_p0=%b bufid_p0=%h wr_p1=%b required %b 1 %b 005 0",
                 c, o_refcnt_wr, ov_refcnt, o_descriptor_wr_p0, ov_bufid_p0, o_descriptor_wr_p1, er, ew);
      else n_pass++;
      tick();
    end
    man_ack0 = 1'b0;
  endtask

  task automatic test_multicast();
    logic er, ew0, ew1;
    logic [1:0] ec;
    logic [8:0] eb;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) drive(1'b1, 9'h1A0, 2'b11);
      else if (c == 1) drive(1'b1, 9'h0AA, 2'b01);
      else drive(1'b0, 9'h000, 2'b00);
      man_ack1 = (c == 3);
      man_ack0 = (c == 6) || (c == 9);
      @(negedge clk);
      er  = (c == 1) || (c == 7);
      ec  = (c == 1) ? 2'd2 : 2'd1;
      ew0 = (c >= 2 && c <= 6) || (c >= 8 && c <= 9);
      ew1 = (c >= 2 && c <= 3);
      eb  = (c <= 6) ? 9'h1A0 : 9'h0AA;
      n_checks++;
      if (o_refcnt_wr !== er || (er && (ov_refcnt !== ec || ov_refcnt_bufid !== eb)) ||
          o_descriptor_wr_p0 !== ew0 || o_descriptor_wr_p1 !== ew1 ||
          (ew0 && ov_bufid_p0 !== eb) || (ew1 && ov_bufid_p1 !== 9'h1A0))
        $display("FAIL multicast c=%0d: refcnt_wr=%b cnt=%0d wr=%b%b bufid_p0=%h required refcnt_wr=%b cnt=%0d wr=%b%b bufid=%h",
                 c, o_refcnt_wr, ov_refcnt, o_descriptor_wr_p1, o_descriptor_wr_p0, ov_bufid_p0, er, ec, ew1, ew0, eb);
      else n_pass++;
      tick();
    end
    man_ack0 = 1'b0;
    man_ack1 = 1'b0;
  endtask

  task automatic test_zero_bitmap();
    logic ef;
    for (int c = 0; c <= 3; c++) begin
      drive(c == 0, 9'h033, 2'b00);
      @(negedge clk);
      ef = (c == 1);
      n_checks++;
      if (o_free_bufid_wr !== ef || (ef && ov_free_bufid !== 9'h033) || o_refcnt_wr !== 1'b0 ||
          o_descriptor_wr_p0 !== 1'b0 || o_descriptor_wr_p1 !== 1'b0)
        $display("FAIL zero_bitmap c=%0d: free=%b bufid=%h refcnt_wr=%b wr=%b%b required free=%b bufid=033 0 00",
                 c, o_free_bufid_wr, ov_free_bufid, o_refcnt_wr, o_descriptor_wr_p1, o_descriptor_wr_p0, ef);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_full();
    logic ok;
    issued_q.delete();
    for (int c = 0; c <= 6; c++) begin
      drive(c <= 5, 9'(c + 1), 2'b01);
      @(negedge clk);
      if (c >= 4) begin
        n_checks++;
        if (o_fifo_full !== (c >= 5))
          $display("FAIL full_flag c=%0d: o_fifo_full=%b required %b", c, o_fifo_full, (c >= 5));
        else n_pass++;
      end
      tick();
    end
    drive(1'b0, 9'h000, 2'b00);
    auto_ack = 1'b1;
    wait_idle(200, "full");
    auto_ack = 1'b0;
    ok = (issued_q.size() == 5);
    for (int i = 0; i < issued_q.size() && i < 5; i++)
      if (issued_q[i] !== 9'(i + 1)) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL full_order: issued %0d descriptors (first %h), required bufids 1..5 in order",
                      issued_q.size(), (issued_q.size() > 0) ? issued_q[0] : 9'h000);
    else n_pass++;
  endtask

  task automatic test_push_pop_full_wrap();
    for (int c = 0; c <= 8; c++) begin
      if (c <= 4) drive(1'b1, 9'(9'h100 + c), 2'b01);
      else if (c == 6) drive(1'b1, 9'h1FF, 2'b10);
      else drive(1'b0, 9'h000, 2'b00);
      man_ack0 = (c == 5);
      @(negedge clk);
      if (c >= 5 && c <= 8) begin
        n_checks++;
        if (o_fifo_full !== 1'b1 || (c == 6 && o_refcnt_wr !== 1'b1))
          $display("FAIL push_pop_full c=%0d: o_fifo_full=%b refcnt_wr=%b required full=1 (pop at c=6)",
                   c, o_fifo_full, o_refcnt_wr);
        else n_pass++;
      end
      tick();
    end
    man_ack0 = 1'b0;
    auto_ack = 1'b1;
    for (int i = 0; i < 3 * D * 3; i++) begin
      i_descriptor_wr = 1'b1;
      iv_tsntag       = {16'($urandom), 32'($urandom)};
      iv_pkt_type     = 3'($urandom);
      iv_bufid        = 9'($urandom);
      iv_outport      = 2'($urandom_range(0, 3));
      tick();
      i_descriptor_wr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle(1000, "wrap");
    auto_ack = 1'b0;
    n_checks++;
    if (m_pops !== m_acc) $display("FAIL wrap_count: popped %0d required %0d accepted", m_pops, m_acc);
    else n_pass++;
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    n_checks++;
    if (ov_dispatch_cnt_p0 !== 32'(m_ack0) || ov_dispatch_cnt_p1 !== 32'(m_ack1) || ov_drop_cnt !== 32'(m_drop + m_free))
      $display("FAIL stats: p0=%0d p1=%0d drop=%0d required %0d %0d %0d",
               ov_dispatch_cnt_p0, ov_dispatch_cnt_p1, ov_drop_cnt, m_ack0, m_ack1, m_drop + m_free);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) drive(1'b1, 9'h0C3, 2'b11);
      else if (c == 1) drive(1'b1, 9'h0C4, 2'b01);
      else drive(1'b0, 9'h000, 2'b00);
      if (c < 3) tick();
    end
    @(negedge clk);
    n_checks++;
    if ({o_descriptor_wr_p1, o_descriptor_wr_p0} !== 2'b11)
      $display("FAIL reset_mid_pre: wr=%b%b required 11", o_descriptor_wr_p1, o_descriptor_wr_p0);
    else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_descriptor_wr_p1, o_descriptor_wr_p0} !== 2'b00 || ov_fsm_state !== 2'd0 || o_fifo_full !== 1'b0)
      $display("FAIL reset_mid_async: wr=%b%b state=%0d full=%b required 00 0 0",
               o_descriptor_wr_p1, o_descriptor_wr_p0, ov_fsm_state, o_fifo_full);
    else n_pass++;
`ifdef DISPATCH_STATS_EN
    n_checks++;
    if ({ov_dispatch_cnt_p0, ov_dispatch_cnt_p1, ov_drop_cnt} !== '0)
      $display("FAIL reset_mid_stats: p0=%0d p1=%0d drop=%0d required 0 0 0",
               ov_dispatch_cnt_p0, ov_dispatch_cnt_p1, ov_drop_cnt);
    else n_pass++;
`endif
    repeat (2) tick();
    rst = 1'b0;
    issued_q.delete();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov_fsm_state !== 2'd0 || o_fifo_full !== 1'b0 || o_refcnt_wr !== 1'b0 || o_free_bufid_wr !== 1'b0)
        $display("FAIL reset_mid_empty c=%0d: state=%0d full=%b refcnt_wr=%b free=%b required 0 0 0 0",
                 c, ov_fsm_state, o_fifo_full, o_refcnt_wr, o_free_bufid_wr);
      else n_pass++;
      tick();
    end
    auto_ack = 1'b1;
    drive(1'b1, 9'h0D1, 2'b10);
    tick();
    drive(1'b0, 9'h000, 2'b00);
    wait_idle(50, "post_reset");
    auto_ack = 1'b0;
    n_checks++;
    if (issued_q.size() != 1 || issued_q[0] !== 9'h0D1)
      $display("FAIL post_reset_issue: issued %0d descriptors, required exactly bufid 0d1", issued_q.size());
    else n_pass++;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst = 1'b1;
    man_ack0 = 1'b0; man_ack1 = 1'b0; a_ack0 = 1'b0; a_ack1 = 1'b0; auto_ack = 1'b0;
    drive(1'b0, 9'h000, 2'b00);
    fork
      monitor();
      ack_driver();
    join_none
    tick();
    test_reset();
    test_unicast();
    test_multicast();
    test_zero_bitmap();
    test_full();
    test_push_pop_full_wrap();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
